// File: rtl/param_array_sorter.sv
// param_array_sorter: collects up to DEPTH unsigned samples, keeps them sorted on arrival
// by parallel compare-and-shift insertion, then drains the sorted frame head first.
module param_array_sorter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             descend,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [WIDTH-1:0] data_out,
    output logic [CW-1:0]    count
);

    typedef enum logic {StLoad, StDrain} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_entry    [DEPTH];
    logic [WIDTH-1:0] w_entry_up [DEPTH];
    logic [WIDTH-1:0] w_entry_dn [DEPTH];
    logic [WIDTH-1:0] w_entry_ins[DEPTH];
    logic [CW-1:0]    r_count;
    logic             r_mode;
    logic             w_desc;
    logic [DEPTH-1:0] w_keep;
    logic [DEPTH-1:0] w_keep_prev;
    logic             w_accept;
    logic             w_take;

    // Insertion network: entries that sort at or before the new sample stay put, the first
    // slot past them takes the sample, everything after moves up by one.
    always_comb begin
        // The first sample of a frame uses the live direction input, later ones the latched mode.
        w_desc = (r_count == '0) ? descend : r_mode;
        w_entry_up[0] = '0;
        w_entry_dn[DEPTH-1] = '0;
        for (int i = 1; i < DEPTH; i++) begin
            w_entry_up[i]   = r_entry[i-1];
            w_entry_dn[i-1] = r_entry[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_keep[i] = 1'b0;
            if (CW'(i) < r_count) begin
                // Equal entries stay ahead of the newcomer, which keeps ties stable.
                w_keep[i] = w_desc ? (r_entry[i] >= data_in) : (r_entry[i] <= data_in);
            end
        end
        w_keep_prev = {w_keep[DEPTH-2:0], 1'b1};
        for (int i = 0; i < DEPTH; i++) begin
            if (w_keep[i]) begin
                w_entry_ins[i] = r_entry[i];
            end else if (w_keep_prev[i]) begin
                w_entry_ins[i] = data_in;
            end else begin
                w_entry_ins[i] = w_entry_up[i];
            end
        end
    end

    // Handshakes, next state and register-decoded outputs.
    always_comb begin
        w_state_next = r_state;
        in_ready     = (r_state == StLoad);
        out_valid    = (r_state == StDrain);
        out_last     = (r_state == StDrain) && (r_count == CW'(1));
        data_out     = r_entry[0];
        count        = r_count;
        w_accept     = in_valid && (r_state == StLoad);
        w_take       = out_ready && (r_state == StDrain);
        case (r_state)
            StLoad: begin
                if (w_accept && (in_last || (r_count == CW'(DEPTH - 1)))) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                if (w_take && (r_count == CW'(1))) begin
                    w_state_next = StLoad;
                end
            end
            default: w_state_next = StLoad;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StLoad;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Sorted storage, occupancy and frame direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_count <= '0;
            r_mode  <= 1'b0;
        end else if (w_accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= w_entry_ins[i];
            end
            r_count <= r_count + CW'(1);
            if (r_count == '0) begin
                r_mode <= descend;
            end
        end else if (w_take) begin
            // Shift toward the head; the vacated top slot reads as zero.
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= w_entry_dn[i];
            end
            r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: doc/param_array_sorter.md
# param_array_sorter

Parametrised frame sorter that collects up to DEPTH unsigned samples over a valid/ready stream. It keeps them ordered as they arrive using parallel compare-and-shift insertion, one sample per cycle. It then drains the sorted frame on an output valid/ready stream. This is the next-generation sort stage of the datapath, generalised in width and depth. It adds a selectable sort direction, short frames and output backpressure.

## Interface
- WIDTH, 8: sample width in bits (>= 1).
- DEPTH, 4: maximum samples per frame (>= 2).
- CW, $clog2(DEPTH+1): width of occupancy count (derived, not overridden).

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- descend  input  1  sort direction: 0 ascending, 1 descending. Sampled with the first accepted sample of a frame.
- in_valid  input  1  input sample valid.
- in_ready  output  1  sorter accepts a sample this cycle.
- in_last  input  1  accepted sample closes the frame early.
- data_in  input  WIDTH  input sample.
- out_valid  output  1  data_out holds a sorted sample.
- out_ready  input  1  downstream accepts data_out.
- out_last  output  1  data_out is the final sample of the frame.
- data_out  output  WIDTH  current head of sorted array.
- count  output  CW  number of occupied entries.

## Operation
- Storage: DEPTH registers entry[0..DEPTH-1]. Entries 0..count-1 are valid and always sorted; entry[0] is the head.
- States: LOAD and DRAIN. Reset state is LOAD.
- LOAD:
  - in_ready=1 and out_valid=0.
  - An accepted sample (in_valid & in_ready) is x. The insertion position p is the number of valid entries e with e <= x (ascending) or e >= x (descending).
  - Entries p..count-1 shift to p+1..count; entry[p]<=x; count<=count+1.
  - Ties are stable: an earlier sample precedes a later equal sample.
  - When count==0, mode_q<=descend with the accept. mode_q holds for the whole frame.
  - Transition to DRAIN when the accepted sample makes count==DEPTH, or when in_last=1 on the accept.
- DRAIN:
  - in_ready=0, out_valid=1, data_out=entry[0], out_last=(count==1).
  - On out_valid & out_ready: entries shift down by one, count<=count-1, and entry[count-1]<=0.
  - When the final sample is taken (count==1), transition to LOAD.
- in_last with zero stored samples cannot occur: in_last is only seen on an accept, so count is >= 1 after it.
- Comparison is unsigned over the full WIDTH. No arithmetic widening.
- Unoccupied entries read as 0. data_out is entry[0] in every state; it is only meaningful while out_valid=1.

## Timing
- Reset values:
  - state=LOAD, all entries=0, count=0, mode_q=0.
  - in_ready=1, out_valid=0, out_last=0, data_out=0.
- Reset assertion clears everything immediately, including mid-frame and mid-drain. The partial frame is discarded. The first accept is possible on the first rising edge after rst_n deasserts.
- Insert: one sample per cycle at full throughput. count and the entries update on the accepting edge.
- Load-to-drain latency: out_valid rises in the cycle after the edge that accepted the closing sample.
- Drain: one sample per cycle while out_ready=1.
  - While out_ready=0, data_out, out_last and count hold stable and out_valid stays high.
- Drain-to-load: in_ready rises in the cycle after the final output handshake. There is no overlap between frames.
- in_valid during DRAIN is ignored (in_ready=0). The upstream holds its data.
- All outputs are decoded from registers. There is no combinational path from in_valid or out_ready to any output.

## Test plan
- Ascending full frame (descend=0): 0x30,0x10,0x40,0x20 back-to-back -> count 1,2,3,4. out_valid on the next cycle. Outputs 0x10,0x20,0x30,0x40, with out_last only on 0x40. in_ready=1 one cycle after.
- Descending frame (descend=1 on first sample, toggled to 0 afterwards): 0x05,0xFF,0x80,0x05 -> 0xFF,0x80,0x05,0x05. Mode stays descending for the whole frame.
- Short frame: 0x22 then 0x11 with in_last=1 -> drain 0x11,0x22, out_last on 0x22, count returns to 0, back in LOAD.
- Backpressure: full ascending frame; hold out_ready=0 for 5 cycles, then toggle it 1,0,1,1,1 -> data_out/out_last stable while stalled. Exactly 4 handshakes occur in order. in_valid pulses during the drain are not accepted.
- Stability and ties: ascending 0x07(a),0x03,0x07(b),0x03 -> 0x03,0x03,0x07,0x07. The bench checks by tagged replay that 0x07(a) precedes 0x07(b).
- Reset mid-operation: assert rst_n=0 after 2 loads, and again after 1 drain handshake -> count=0, out_valid=0, in_ready=1 immediately. A following clean frame 0x02,0x01,0x04,0x03 sorts to 0x01..0x04.
